alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//  Upstream/downstream register stage around the combinational 8-bit ALU. Latches A/B operands from
//  the data bus, drives them plus op controls into the ALU, waits a settle window, then registers the
//  ALU result and N/Z flags. Gives the control unit a start/busy/done handshake and optional A-writeback.
// PARAMETERS
//  WIDTH          8   operand/result width; ALU is 8-bit, other values are not supported
//  SETTLE_CYCLES  1   cycles in ISSUE before capture (ALU propagation budget); legal range 1..15
// PORTS
//  i_clk          in   1      single clock, all state on rising edge
//  i_rst          in   1      synchronous, active-high reset
//  i_bus          in   WIDTH  data bus value
//  i_loadA        in   1      write i_bus into A register (IDLE only)
//  i_loadB        in   1      write i_bus into B register (IDLE only)
//  i_start        in   1      begin operation (IDLE only)
//  i_aluOp        in   2      00 add/sub, 01 and, 10 xor, 11 shift; sampled at start
//  i_sub          in   1      subtract select for op 00; sampled at start
//  i_shiftLeft    in   1      shift direction for op 11; sampled at start
//  i_writeBackA   in   1      on capture also write result into A; sampled at start
//  i_aluY         in   WIDTH  ALU result (combinational return path)
//  i_aluNegative  in   1      ALU negative flag
//  i_aluZero      in   1      ALU zero flag
//  o_a, o_b       out  WIDTH  operand registers, to ALU i_a/i_b
//  o_aluOp        out  2      latched op; o_sub, o_shiftLeft out 1 each, latched controls
//  o_result       out  WIDTH  captured result register
//  o_flagN        out  1      captured negative flag; o_flagZ out 1, captured zero flag
//  o_busy         out  1      high in ISSUE and CAPTURE
//  o_done         out  1      one-cycle pulse, the cycle after capture edge
// BEHAVIOUR
//  Reset (sync, i_rst=1 at edge): state IDLE; o_a,o_b,o_result=0; o_aluOp=00; o_sub,o_shiftLeft=0;
//   o_flagN=0, o_flagZ=0; o_busy=0, o_done=0; settle count=0. Reset mid-operation aborts: no done, no capture.
//  FSM: IDLE -start-> ISSUE; ISSUE holds SETTLE_CYCLES cycles then -> CAPTURE; CAPTURE -> IDLE (1 cycle).
//  Capture edge (leaving CAPTURE): o_result<=i_aluY, o_flagN<=i_aluNegative, o_flagZ<=i_aluZero;
//   if writeBack latched: o_a<=i_aluY. o_done=1 for exactly the following cycle (state IDLE).
//  Latency: start edge to done high = SETTLE_CYCLES+2 cycles (default 3).
//  Loads: honoured only in IDLE (incl. the cycle o_done is high); ignored while o_busy=1.
//  loadA+loadB same cycle: both take i_bus. Load + start same cycle: register updates on that edge,
//   so the operation uses the newly loaded value.
//  start while busy: ignored, not queued. Op controls outputs stable for the whole ISSUE/CAPTURE window.
//  Flags and result hold their values until the next capture; no change on loads or on aborted ops.
//  All arithmetic is in the ALU; this block performs no width extension or carry generation.
// STRUCTURE
//  alu_pkg: alu_op_t enum {ALU_ADD=2'b00, ALU_AND=2'b01, ALU_XOR=2'b10, ALU_SHIFT=2'b11},
//   stage_state_t enum {ST_IDLE, ST_ISSUE, ST_CAPTURE}, ALU_WIDTH=8 constant.
//  One sub-module: settle_counter (load on ISSUE entry, count down, expire flag); rest is flat.
// TESTING (bench models ALU behaviourally on o_a/o_b/o_aluOp)
//  loadA 0x05, loadB 0x03, start op=00 sub=0 -> done at start+3, o_result=0x08, N=0, Z=0.
//  A=0x03, B=0x03, op=00 sub=1 -> o_result=0x00, Z=1, N=0; then A=0x01,B=0x02 sub -> 0xFF, N=1, Z=0.
//  A=0x81, B=0x01, op=11 shiftLeft=1, writeBack=1 -> o_result=0x02, o_a=0x02 after capture.
//  loadA 0x10 while busy, start while busy -> o_a unchanged, no second done; start in done cycle accepted.
//  i_rst pulsed in ISSUE -> next cycle all outputs reset values, no o_done, prior result cleared to 0.
//  SETTLE_CYCLES=4: loadA+start same cycle with bus=0x7F, B=0x01 add -> done at start+6, result 0x80, N=1.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared types and constants for the ALU operand/result register stage.
//   - alu_op_t      : ALU operation encoding driven to the combinational ALU
//   - stage_state_t : sequencing states of the operand stage
//   - ALU_WIDTH     : datapath width of the ALU
//   - SETTLE_CNT_W  : width of the settle-window down-counter
//   - settle_load() : value loaded into the settle counter on ISSUE entry
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_WIDTH    = 8;
    localparam int SETTLE_CNT_W = 4;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_AND   = 2'b01,
        ALU_XOR   = 2'b10,
        ALU_SHIFT = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE
    } stage_state_t;

    // The counter expires when it reaches zero, so a window of N cycles in
    // ISSUE needs a start value of N-1.
    function automatic logic [SETTLE_CNT_W-1:0] settle_load(input int settle_cycles);
        settle_load = SETTLE_CNT_W'(settle_cycles - 1);
    endfunction

endpackage

// File: rtl/alu_operand_stage_settle_counter.sv
// ---------------------------------------------------------------------------
// settle_counter
//   Down-counter that times the ALU propagation window spent in ISSUE.
//   Ports:
//     i_clk       clock, rising edge
//     i_rst       synchronous active-high reset (count cleared to 0)
//     i_load      load the start value (asserted on the edge entering ISSUE)
//     i_en        count down while asserted (in ISSUE)
//     o_expired   count is zero: the settle window has elapsed
// ---------------------------------------------------------------------------
module settle_counter
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [SETTLE_CNT_W-1:0] LOAD_VAL = settle_load(SETTLE_CYCLES);

    logic [SETTLE_CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= LOAD_VAL;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
//   Register stage wrapped around the combinational 8-bit ALU. Operands are
//   latched from the data bus, op controls are latched at start, the ALU is
//   given a settle window, then result and N/Z flags are captured.
//   Ports:
//     i_clk, i_rst              clock / synchronous active-high reset
//     i_bus                     data bus for operand loads
//     i_loadA, i_loadB          operand loads (honoured in IDLE only)
//     i_start                   begin operation (IDLE only)
//     i_aluOp, i_sub,
//     i_shiftLeft, i_writeBackA op controls, sampled at start
//     i_aluY, i_aluNegative,
//     i_aluZero                 combinational ALU return path
//     o_a, o_b                  operand registers to the ALU
//     o_aluOp, o_sub,
//     o_shiftLeft               latched op controls to the ALU
//     o_result, o_flagN,
//     o_flagZ                   captured result and flags
//     o_busy                    high in ISSUE and CAPTURE
//     o_done                    one-cycle pulse after the capture edge
// ---------------------------------------------------------------------------
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int WIDTH         = ALU_WIDTH,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_bus,
    input  logic             i_loadA,
    input  logic             i_loadB,
    input  logic             i_start,
    input  logic [1:0]       i_aluOp,
    input  logic             i_sub,
    input  logic             i_shiftLeft,
    input  logic             i_writeBackA,
    input  logic [WIDTH-1:0] i_aluY,
    input  logic             i_aluNegative,
    input  logic             i_aluZero,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b,
    output logic [1:0]       o_aluOp,
    output logic             o_sub,
    output logic             o_shiftLeft,
    output logic [WIDTH-1:0] o_result,
    output logic             o_flagN,
    output logic             o_flagZ,
    output logic             o_busy,
    output logic             o_done
);

    stage_state_t     r_state;
    stage_state_t     w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    alu_op_t          r_alu_op;
    logic             r_sub;
    logic             r_shift_left;
    logic             r_write_back;
    logic [WIDTH-1:0] r_result;
    logic             r_flag_n;
    logic             r_flag_z;
    logic             r_done;
    logic             w_idle;
    logic             w_start_accept;
    logic             w_capture;
    logic             w_settle_expired;

    assign w_idle         = (r_state == ST_IDLE);
    assign w_start_accept = w_idle && i_start;
    assign w_capture      = (r_state == ST_CAPTURE);

    settle_counter #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (w_start_accept),
        .i_en      (r_state == ST_ISSUE),
        .o_expired (w_settle_expired)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (i_start)          w_state_next = ST_ISSUE;
            ST_ISSUE:   if (w_settle_expired) w_state_next = ST_CAPTURE;
            ST_CAPTURE:                       w_state_next = ST_IDLE;
            default:                          w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_alu_op     <= ALU_ADD;
            r_sub        <= 1'b0;
            r_shift_left <= 1'b0;
            r_write_back <= 1'b0;
            r_result     <= '0;
            r_flag_n     <= 1'b0;
            r_flag_z     <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_capture;

            // Loads and start share the edge: an operand loaded together
            // with start is already in place for the first ISSUE cycle.
            if (w_idle) begin
                if (i_loadA) r_a <= i_bus;
                if (i_loadB) r_b <= i_bus;
            end

            if (w_start_accept) begin
                r_alu_op     <= alu_op_t'(i_aluOp);
                r_sub        <= i_sub;
                r_shift_left <= i_shiftLeft;
                r_write_back <= i_writeBackA;
            end

            // Loads are blocked outside IDLE, so writeback never races a load.
            if (w_capture) begin
                r_result <= i_aluY;
                r_flag_n <= i_aluNegative;
                r_flag_z <= i_aluZero;
                if (r_write_back) r_a <= i_aluY;
            end
        end
    end

    assign o_a         = r_a;
    assign o_b         = r_b;
    assign o_aluOp     = r_alu_op;
    assign o_sub       = r_sub;
    assign o_shiftLeft = r_shift_left;
    assign o_result    = r_result;
    assign o_flagN     = r_flag_n;
    assign o_flagZ     = r_flag_z;
    assign o_busy      = !w_idle;
    assign o_done      = r_done;

endmodule

// File: tb/tb_alu_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_stage
//   Directed bench for alu_operand_stage. Two instances share clock, reset,
//   bus, loads and op controls; each has its own start and its own
//   behavioural ALU. u_dut uses the default settle window, u_dut4 uses 4.
// ---------------------------------------------------------------------------
module tb_alu_operand_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] bus;
    logic       load_a, load_b;
    logic       start1, start4;
    logic [1:0] alu_op;
    logic       sub, shl, wb;

    logic [7:0] y1, y4;
    logic       n1, z1, n4, z4;
    logic [7:0] a1, b1, res1, a4, b4, res4;
    logic [1:0] op1, op4;
    logic       sub1, sl1, fn1, fz1, busy1, done1;
    logic       sub4, sl4, fn4, fz4, busy4, done4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_operand_stage u_dut (
        .i_clk(clk), .i_rst(rst), .i_bus(bus), .i_loadA(load_a), .i_loadB(load_b),
        .i_start(start1), .i_aluOp(alu_op), .i_sub(sub), .i_shiftLeft(shl),
        .i_writeBackA(wb), .i_aluY(y1), .i_aluNegative(n1), .i_aluZero(z1),
        .o_a(a1), .o_b(b1), .o_aluOp(op1), .o_sub(sub1), .o_shiftLeft(sl1),
        .o_result(res1), .o_flagN(fn1), .o_flagZ(fz1), .o_busy(busy1), .o_done(done1)
    );

    alu_operand_stage #(.SETTLE_CYCLES(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_bus(bus), .i_loadA(load_a), .i_loadB(load_b),
        .i_start(start4), .i_aluOp(alu_op), .i_sub(sub), .i_shiftLeft(shl),
        .i_writeBackA(wb), .i_aluY(y4), .i_aluNegative(n4), .i_aluZero(z4),
        .o_a(a4), .o_b(b4), .o_aluOp(op4), .o_sub(sub4), .o_shiftLeft(sl4),
        .o_result(res4), .o_flagN(fn4), .o_flagZ(fz4), .o_busy(busy4), .o_done(done4)
    );

    // Behavioural ALU: returns {N, Z, Y}.
    function automatic logic [9:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [1:0] op, input logic s,
                                             input logic left);
        logic [7:0] y;
        case (op)
            2'b00:   y = s ? (a - b) : (a + b);
            2'b01:   y = a & b;
            2'b10:   y = a ^ b;
            default: y = left ? {a[6:0], 1'b0} : {1'b0, a[7:1]};
        endcase
        return {y[7], (y == 8'h00), y};
    endfunction

    always_comb {n1, z1, y1} = alu_model(a1, b1, op1, sub1, sl1);
    always_comb {n4, z4, y4} = alu_model(a4, b4, op4, sub4, sl4);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
        bus = a; load_a = 1'b1; tick(); load_a = 1'b0;
        bus = b; load_b = 1'b1; tick(); load_b = 1'b0;
    endtask

    // Pulse start on the selected instance, wait (bounded) for done, check
    // the latency and that done drops again after one cycle.
    task automatic do_op(input bit sel, input logic [1:0] op, input logic s,
                         input logic left, input logic w, input int exp_lat);
        int lat;
        alu_op = op; sub = s; shl = left; wb = w;
        if (sel) start4 = 1'b1; else start1 = 1'b1;
        tick();
        start1 = 1'b0; start4 = 1'b0; load_a = 1'b0; load_b = 1'b0;
        lat = 1;
        while (!(sel ? done4 : done1) && lat < 20) begin
            tick();
            lat++;
        end
        check("latency", lat, exp_lat);
        tick();
        check("done_pulse", sel ? done4 : done1, 1'b0);
        if (sel) $display("op=%0d sel=4 a=%02h b=%02h result=%02h N=%0b Z=%0b lat=%0d", op, a4, b4, res4, fn4, fz4, lat);
        else     $display("op=%0d sel=1 a=%02h b=%02h result=%02h N=%0b Z=%0b lat=%0d", op, a1, b1, res1, fn1, fz1, lat);
    endtask

    initial begin
        rst = 1'b1; bus = 8'h00; load_a = 1'b0; load_b = 1'b0;
        start1 = 1'b0; start4 = 1'b0; alu_op = 2'b00; sub = 1'b0; shl = 1'b0; wb = 1'b0;
        tick(); tick();
        check("rst_a", a1, 8'h00);
        check("rst_b", b1, 8'h00);
        check("rst_result", res1, 8'h00);
        check("rst_flags", {fn1, fz1}, 2'b00);
        check("rst_busy_done", {busy1, done1}, 2'b00);
        check("rst_op", {op1, sub1, sl1}, 4'b0000);
        rst = 1'b0;

        // 5 + 3
        load_ab(8'h05, 8'h03);
        check("load_a", a1, 8'h05);
        check("load_b", b1, 8'h03);
        do_op(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3);
        check("add_result", res1, 8'h08);
        check("add_flags", {fn1, fz1}, 2'b00);

        // 3 - 3 = 0, then 1 - 2 = FF
        load_ab(8'h03, 8'h03);
        do_op(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 3);
        check("sub0_result", res1, 8'h00);
        check("sub0_flags", {fn1, fz1}, 2'b01);
        load_ab(8'h01, 8'h02);
        do_op(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 3);
        check("subneg_result", res1, 8'hFF);
        check("subneg_flags", {fn1, fz1}, 2'b10);

        // 0x81 << 1 with writeback into A
        load_ab(8'h81, 8'h01);
        do_op(1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 3);
        check("shl_result", res1, 8'h02);
        check("shl_wb_a", a1, 8'h02);
        check("shl_b", b1, 8'h01);

        // A=2, B=1 add; load and start while busy are ignored
        alu_op = 2'b00; sub = 1'b0; shl = 1'b0; wb = 1'b0;
        start1 = 1'b1;
        tick();
        bus = 8'h10; load_a = 1'b1; alu_op = 2'b01;
        tick();
        check("busy_load_a", a1, 8'h02);
        check("busy_op_stable", op1, 2'b00);
        check("busy_no_done", done1, 1'b0);
        check("busy_flag", busy1, 1'b1);
        load_a = 1'b0; start1 = 1'b0; alu_op = 2'b00;
        tick();
        check("busy_done", done1, 1'b1);
        check("busy_result", res1, 8'h03);
        // Load B and start in the done cycle: both honoured, new B used
        bus = 8'h05; load_b = 1'b1; start1 = 1'b1;
        tick();
        load_b = 1'b0; start1 = 1'b0;
        check("donecyc_busy", busy1, 1'b1);
        check("donecyc_load_b", b1, 8'h05);
        check("donecyc_no_done", done1, 1'b0);
        tick();
        check("donecyc_no_done2", done1, 1'b0);
        tick();
        check("donecyc_done", done1, 1'b1);
        check("donecyc_result", res1, 8'h07);
        tick();
        check("donecyc_idle", {busy1, done1}, 2'b00);
        $display("op=0 sel=1 busy/done-cycle sequence result=%02h", res1);

        // Reset while in ISSUE aborts and clears everything
        start1 = 1'b1;
        tick();
        start1 = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_result", res1, 8'h00);
        check("abort_ab", {a1, b1}, 16'h0000);
        check("abort_busy_done", {busy1, done1}, 2'b00);
        tick();
        check("abort_no_done", {busy1, done1}, 2'b00);
        $display("reset abort: result=%02h busy=%0b done=%0b", res1, busy1, done1);

        // SETTLE_CYCLES=4: load A together with start, 0x7F + 0x01
        bus = 8'h01; load_b = 1'b1; tick(); load_b = 1'b0;
        bus = 8'h7F; load_a = 1'b1;
        do_op(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 6);
        check("s4_result", res4, 8'h80);
        check("s4_flags", {fn4, fz4}, 2'b10);
        check("s4_other_idle", res1, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
